fft_dif_ctrl_param: RTL and testbench

- Parametrised controller for an in-place radix-2 DIF FFT over two dual-port SRAM banks of N/2 words each, with N = 2^LOG2N.
- Sequences four phases: sample load, LOG2N butterfly stages, per-stage write-back drain, and bit-reversal-corrected unload.
- Drives bank enables and addresses, butterfly input/output swap selects, and twiddle index. The controller carries no data.
- Generalises the fixed 64-point, 3-cycle controller in point count and butterfly latency. Adds a load/unload handshake, per-stage hazard drain and natural-order output.

---
 rtl/fft_pkg.sv | 55 +++++
 rtl/fft_ctrl_dly.sv | 32 +++
 rtl/fft_dif_ctrl_param.sv | 183 ++++++++++++++++++
 tb/tb_fft_dif_ctrl_param.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared types and index helpers for the radix-2 DIF FFT
//               controller (state encoding, bank mapping, bit reversal).
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int MAX_LOG2N = 12;
    localparam int DEF_LOG2N = 6;
    localparam int DEF_N     = 1 << DEF_LOG2N;
    localparam int DEF_AW    = DEF_LOG2N - 1;

    typedef logic [MAX_LOG2N-1:0] idx_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_UNLOAD  = 3'd4
    } fft_state_e;

    function automatic int fft_n(input int log2n);
        return 1 << log2n;
    endfunction

    function automatic int fft_aw(input int log2n);
        return log2n - 1;
    endfunction

    // Bank number of a sample index
    function automatic logic parity(input idx_t v);
        return ^v;
    endfunction

    function automatic idx_t bitrev(input idx_t v, input int bits);
        idx_t r;
        r = '0;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            if (i < bits) r[i] = v[bits-1-i];
        end
        return r;
    endfunction

    // Open a zero at bit position pos, shifting the upper bits left
    function automatic idx_t insert_zero(input idx_t v, input int pos);
        idx_t lo;
        lo = (idx_t'(1) << pos) - idx_t'(1);
        return ((v & ~lo) << 1) | (v & lo);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_ctrl_dly.sv
`default_nettype none
// ============================================================================
// Module      : fft_ctrl_dly
// Description : Parametrised width x depth shift register with synchronous
//               clear, used to align control with RAM/butterfly latency.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_ctrl_dly #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_data = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fft_dif_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : fft_dif_ctrl_param
// Description : Address/control sequencer for an in-place radix-2 DIF FFT
//               over two N/2-word banks: load, stages, drain, unload.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_dif_ctrl_param #(
    parameter int LOG2N    = 6,
    parameter int BFLY_LAT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         busy,
    output logic                         we_b0,
    output logic                         we_b1,
    output logic                         re_b0,
    output logic                         re_b1,
    output logic [LOG2N-2:0]             waddr_b0,
    output logic [LOG2N-2:0]             waddr_b1,
    output logic [LOG2N-2:0]             raddr_b0,
    output logic [LOG2N-2:0]             raddr_b1,
    output logic                         swap_in,
    output logic                         swap_out,
    output logic [LOG2N-2:0]             tw_idx,
    output logic [$clog2(LOG2N+1)-1:0]   stage,
    output logic                         out_sel,
    output logic                         out_valid,
    output logic                         out_last,
    output logic                         done
);

    import fft_pkg::*;

    localparam int N      = 1 << LOG2N;
    localparam int AW     = LOG2N - 1;
    localparam int SW     = $clog2(LOG2N + 1);
    localparam int WB_DLY = BFLY_LAT + 1;
    localparam int DW     = $clog2(WB_DLY + 1);

    fft_state_e         r_state;
    logic [LOG2N-1:0]   r_cnt;
    logic [SW-1:0]      r_stage;
    logic [DW-1:0]      r_drain;
    logic               r_rd_done;
    logic               r_done;

    logic [LOG2N-1:0]   w_a, w_b, w_r;
    logic               w_swap, w_rbank, w_lbank;
    logic               w_cre, w_ure, w_lwe, w_ilast;
    logic [AW-1:0]      w_craddr0, w_craddr1, w_uaddr, w_tw;
    logic               w_wb_we;
    logic [AW-1:0]      w_wb_a0, w_wb_a1;

    always_comb begin
        w_a     = LOG2N'(insert_zero(idx_t'(r_cnt), LOG2N - 1 - int'(r_stage)));
        w_b     = w_a | (LOG2N'(1) << (LOG2N - 1 - int'(r_stage)));
        w_r     = LOG2N'(bitrev(idx_t'(r_cnt), LOG2N));
        w_swap  = parity(idx_t'(w_a));
        w_rbank = parity(idx_t'(w_r));
        w_lbank = parity(idx_t'(r_cnt));
    end

    assign w_cre   = (r_state == ST_COMPUTE);
    assign w_ure   = (r_state == ST_UNLOAD) && !r_rd_done;
    assign w_lwe   = (r_state == ST_LOAD) && in_valid;
    assign w_ilast = (r_cnt == '1);

    // Bank P(a) always fetches element a; the other bank fetches its partner b
    assign w_craddr0 = !w_cre ? '0 : (w_swap ? AW'(w_b >> 1) : AW'(w_a >> 1));
    assign w_craddr1 = !w_cre ? '0 : (w_swap ? AW'(w_a >> 1) : AW'(w_b >> 1));
    assign w_uaddr   = AW'(w_r >> 1);
    assign w_tw      = w_cre ? AW'(r_cnt << r_stage) : AW'(0);

    assign re_b0    = w_cre | (w_ure & !w_rbank);
    assign re_b1    = w_cre | (w_ure & w_rbank);
    assign raddr_b0 = (w_ure && !w_rbank) ? w_uaddr : w_craddr0;
    assign raddr_b1 = (w_ure && w_rbank)  ? w_uaddr : w_craddr1;

    fft_ctrl_dly #(
        .WIDTH (2 + 2*AW),
        .DEPTH (WB_DLY)
    ) u_wb_dly (
        .clk    (clk),
        .rst    (rst),
        .i_data ({w_cre, w_cre & w_swap, w_craddr0, w_craddr1}),
        .o_data ({w_wb_we, swap_out, w_wb_a0, w_wb_a1})
    );

    fft_ctrl_dly #(
        .WIDTH (4 + AW),
        .DEPTH (1)
    ) u_rd_dly (
        .clk    (clk),
        .rst    (rst),
        .i_data ({w_cre & w_swap, w_tw, w_ure, w_ure & w_rbank, w_ure & w_ilast}),
        .o_data ({swap_in, tw_idx, out_valid, out_sel, out_last})
    );

    // Load writes and write-back never coincide: stages start only after LOAD
    assign we_b0    = (w_lwe & !w_lbank) | w_wb_we;
    assign we_b1    = (w_lwe & w_lbank) | w_wb_we;
    assign waddr_b0 = (w_lwe && !w_lbank) ? AW'(r_cnt >> 1) : w_wb_a0;
    assign waddr_b1 = (w_lwe && w_lbank)  ? AW'(r_cnt >> 1) : w_wb_a1;

    assign in_ready = (r_state == ST_LOAD);
    assign busy     = (r_state != ST_IDLE);
    assign stage    = r_stage;
    assign done     = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_stage   <= '0;
            r_drain   <= '0;
            r_rd_done <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_cnt   <= '0;
                        r_stage <= '0;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        if (r_cnt == LOG2N'(N - 1)) begin
                            r_state <= ST_COMPUTE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + LOG2N'(1);
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (r_cnt == LOG2N'(N/2 - 1)) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= '0;
                        r_drain <= '0;
                    end else begin
                        r_cnt <= r_cnt + LOG2N'(1);
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == DW'(WB_DLY - 1)) begin
                        r_drain <= '0;
                        if (r_stage == SW'(LOG2N - 1)) begin
                            r_state   <= ST_UNLOAD;
                            r_stage   <= '0;
                            r_rd_done <= 1'b0;
                        end else begin
                            r_state <= ST_COMPUTE;
                            r_stage <= r_stage + SW'(1);
                        end
                    end else begin
                        r_drain <= r_drain + DW'(1);
                    end
                end
                ST_UNLOAD: begin
                    // One extra cycle after the last read lets out_last emerge
                    if (r_rd_done) begin
                        r_state   <= ST_IDLE;
                        r_rd_done <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        if (w_ilast) r_rd_done <= 1'b1;
                        r_cnt <= r_cnt + LOG2N'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_dif_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_dif_ctrl_param
// Description : Randomised bench for two controller configurations against a
//               cycle-scheduled reference trace built from the bank/order rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_dif_ctrl_param;

    localparam int MAXT = 1024;

    typedef struct packed {
        logic       in_ready, busy, we0, we1, re0, re1;
        logic [7:0] wa0, wa1, ra0, ra1;
        logic       swap_in, swap_out;
        logic [7:0] tw;
        logic [3:0] stage;
        logic       out_sel, out_valid, out_last, done;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_v [2];
    logic inv_v   [2];
    obs_t obs     [2];

    int lg   [2] = '{3, 6};
    int blat [2] = '{2, 4};

    int n_vec = 0;
    int n_err = 0;
    int cur_t = 0;

    obs_t e_q   [MAXT];
    bit   m_rd  [MAXT];
    bit   m_stg [MAXT];
    bit   vin   [MAXT];
    bit   sst   [MAXT];

    always #5 clk = ~clk;

    // ---------------- configuration 0: N=8, BFLY_LAT=2 ----------------
    logic       a_in_ready, a_busy, a_we0, a_we1, a_re0, a_re1;
    logic [1:0] a_wa0, a_wa1, a_ra0, a_ra1, a_tw, a_stage;
    logic       a_swin, a_swout, a_osel, a_oval, a_olast, a_done;

    fft_dif_ctrl_param #(.LOG2N(3), .BFLY_LAT(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(inv_v[0]),
        .in_ready(a_in_ready), .busy(a_busy), .we_b0(a_we0), .we_b1(a_we1),
        .re_b0(a_re0), .re_b1(a_re1), .waddr_b0(a_wa0), .waddr_b1(a_wa1),
        .raddr_b0(a_ra0), .raddr_b1(a_ra1), .swap_in(a_swin), .swap_out(a_swout),
        .tw_idx(a_tw), .stage(a_stage), .out_sel(a_osel), .out_valid(a_oval),
        .out_last(a_olast), .done(a_done)
    );

    assign obs[0] = {a_in_ready, a_busy, a_we0, a_we1, a_re0, a_re1,
                     8'(a_wa0), 8'(a_wa1), 8'(a_ra0), 8'(a_ra1), a_swin, a_swout,
                     8'(a_tw), 4'(a_stage), a_osel, a_oval, a_olast, a_done};

    // ---------------- configuration 1: N=64, BFLY_LAT=4 ----------------
    logic       b_in_ready, b_busy, b_we0, b_we1, b_re0, b_re1;
    logic [4:0] b_wa0, b_wa1, b_ra0, b_ra1, b_tw;
    logic [2:0] b_stage;
    logic       b_swin, b_swout, b_osel, b_oval, b_olast, b_done;

    fft_dif_ctrl_param #(.LOG2N(6), .BFLY_LAT(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(inv_v[1]),
        .in_ready(b_in_ready), .busy(b_busy), .we_b0(b_we0), .we_b1(b_we1),
        .re_b0(b_re0), .re_b1(b_re1), .waddr_b0(b_wa0), .waddr_b1(b_wa1),
        .raddr_b0(b_ra0), .raddr_b1(b_ra1), .swap_in(b_swin), .swap_out(b_swout),
        .tw_idx(b_tw), .stage(b_stage), .out_sel(b_osel), .out_valid(b_oval),
        .out_last(b_olast), .done(b_done)
    );

    assign obs[1] = {b_in_ready, b_busy, b_we0, b_we1, b_re0, b_re1,
                     8'(b_wa0), 8'(b_wa1), 8'(b_ra0), 8'(b_ra1), b_swin, b_swout,
                     8'(b_tw), 4'(b_stage), b_osel, b_oval, b_olast, b_done};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0d: got %0d, expected %0d", tag, cur_t, act, exp);
        end
    endtask

    function automatic int par(input int x);
        return $countones(x) % 2;
    endfunction

    function automatic int rev(input int x, input int bits);
        int r = 0;
        int v = x;
        for (int i = 0; i < bits; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic cmp_cycle(input int d, input int t);
        obs_t o, x;
        o = obs[d];
        x = e_q[t];
        cur_t = t;
        chk("busy", o.busy, x.busy);
        chk("in_ready", o.in_ready, x.in_ready);
        chk("we_b0", o.we0, x.we0);
        chk("we_b1", o.we1, x.we1);
        chk("re_b0", o.re0, x.re0);
        chk("re_b1", o.re1, x.re1);
        chk("out_valid", o.out_valid, x.out_valid);
        chk("out_last", o.out_last, x.out_last);
        chk("done", o.done, x.done);
        if (x.we0) chk("waddr_b0", o.wa0, x.wa0);
        if (x.we1) chk("waddr_b1", o.wa1, x.wa1);
        if (x.re0) chk("raddr_b0", o.ra0, x.ra0);
        if (x.re1) chk("raddr_b1", o.ra1, x.ra1);
        if (x.we0 && x.we1) chk("swap_out", o.swap_out, x.swap_out);
        if (m_rd[t]) begin
            chk("swap_in", o.swap_in, x.swap_in);
            chk("tw_idx", o.tw, x.tw);
        end
        if (m_stg[t]) chk("stage", o.stage, x.stage);
        if (x.out_valid) chk("out_sel", o.out_sel, x.out_sel);
    endtask

    // Build the expected cycle trace of one frame, then drive and compare it.
    // t=0 is the cycle in which start is presented to the idle controller.
    task automatic run_frame(input int d, input bit gaps);
        int L, N, W, t, c, pos, a, b, r, sw, t_done, first_done;
        L = lg[d];
        N = 1 << L;
        W = blat[d] + 1;
        for (int i = 0; i < MAXT; i++) begin
            e_q[i] = '0; m_rd[i] = 0; m_stg[i] = 0;
            vin[i] = 1'($urandom_range(0, 1));
            sst[i] = 0;
        end
        t = 1; c = 0;
        while (c < N) begin
            vin[t] = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            e_q[t].in_ready = 1;
            if (vin[t]) begin
                if (par(c) == 1) begin e_q[t].we1 = 1; e_q[t].wa1 = 8'(c / 2); end
                else             begin e_q[t].we0 = 1; e_q[t].wa0 = 8'(c / 2); end
                c++;
            end
            t++;
        end
        for (int s = 0; s < L; s++) begin
            pos = L - 1 - s;
            for (int k = 0; k < N/2; k++) begin
                a  = ((k >> pos) << (pos + 1)) + (k % (1 << pos));
                b  = a + (1 << pos);
                sw = par(a);
                e_q[t].re0 = 1; e_q[t].re1 = 1;
                e_q[t].ra0 = 8'((sw == 0) ? a / 2 : b / 2);
                e_q[t].ra1 = 8'((sw == 0) ? b / 2 : a / 2);
                e_q[t].stage = 4'(s); m_stg[t] = 1;
                e_q[t+1].swap_in = 1'(sw);
                e_q[t+1].tw = 8'((k << s) % (N/2));
                m_rd[t+1] = 1;
                e_q[t+W].we0 = 1; e_q[t+W].we1 = 1;
                e_q[t+W].wa0 = e_q[t].ra0; e_q[t+W].wa1 = e_q[t].ra1;
                e_q[t+W].swap_out = 1'(sw);
                t++;
            end
            t += W;
        end
        for (int i = 0; i < N; i++) begin
            r = rev(i, L);
            if (par(r) == 1) begin e_q[t].re1 = 1; e_q[t].ra1 = 8'(r / 2); end
            else             begin e_q[t].re0 = 1; e_q[t].ra0 = 8'(r / 2); end
            e_q[t+1].out_valid = 1;
            e_q[t+1].out_sel = 1'(par(r));
            e_q[t+1].out_last = (i == N - 1);
            t++;
        end
        t_done = t + 1;
        e_q[t_done].done = 1;
        for (int i = 1; i < t_done; i++) begin
            e_q[i].busy = 1;
            sst[i] = ($urandom_range(0, 3) == 0);
        end
        sst[0] = 1;
        first_done = -1;
        for (int i = 0; i <= t_done + 1; i++) begin
            @(negedge clk);
            start_v[d] = sst[i];
            inv_v[d] = vin[i];
            #1;
            if (obs[d].done === 1'b1 && first_done < 0) first_done = i;
            cmp_cycle(d, i);
        end
        start_v[d] = 0;
        inv_v[d] = 0;
        if (!gaps) begin
            cur_t = first_done;
            chk("frame_len", 32'(first_done - 1), 32'(N + L * (N/2 + W) + N + 1));
        end
    endtask

    task automatic check_idle_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk(tag, 32'(|obs[d]), 32'd0);
            chk("busy_rst", obs[d].busy, 1'b0);
        end
    endtask

    task automatic reset_mid_compute();
        @(negedge clk);
        start_v[0] = 1; inv_v[0] = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start_v[0] = 0;
        end
        cur_t = 12;
        chk("mid_compute_busy", obs[0].busy, 1'b1);
        chk("mid_compute_re", obs[0].re0 & obs[0].re1, 1'b1);
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_idle_zero("rst_outs");
        end
        rst = 0;
        inv_v[0] = 0;
    endtask

    initial begin
        start_v[0] = 0; start_v[1] = 0;
        inv_v[0] = 1; inv_v[1] = 1;
        rst = 1;
        repeat (3) @(negedge clk);
        #1;
        check_idle_zero("reset_outs");
        rst = 0;
        inv_v[0] = 0; inv_v[1] = 0;

        run_frame(0, 1'b0);
        for (int i = 0; i < 3; i++) run_frame(0, 1'b1);
        reset_mid_compute();
        run_frame(0, 1'b0);
        run_frame(1, 1'b0);
        for (int i = 0; i < 2; i++) run_frame(1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
